// File: rtl/alu_operand_sequencer.sv
// Switch-driven ALU front end: debounces KEY[1:0] and walks an A -> B -> opcode capture
// sequence, publishing one registered operand word with a single-cycle valid strobe.

module alu_key_cond #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q, deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flip;

  // The level flips on the last stable cycle, so the press fires on the same edge the level drops.
  assign flip    = (sync2_q != deb_q) && (cnt_q == CNT_MAX);
  assign press_o = flip && deb_q;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    deb_d = deb_q;
    if (sync2_q == deb_q) cnt_d = '0;
    if (flip) begin
      cnt_d = '0;
      deb_d = ~deb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

module alu_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [9:0] SW,
  input  logic [1:0] KEY,
  output logic [9:0] operand_word,
  output logic       word_valid,
  output logic [1:0] seq_state
);
  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    READY   = 2'd3
  } state_t;

  state_t     state_q;
  logic [3:0] a_q, b_q;
  logic [9:0] word_q;
  logic       valid_q;
  logic [1:0] press;
  logic       unused_sw;

  assign unused_sw = ^SW[9:4];

  for (genvar k = 0; k < 2; k++) begin : g_key
    alu_key_cond #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_key (
      .clk    (CLOCK_50),
      .rst_n  (RESET_N),
      .key_i  (KEY[k]),
      .press_o(press[k])
    );
  end

  // Cancel takes priority over advance when both events land on one edge.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (press[1]) begin
        state_q <= LOAD_A;
        a_q     <= '0;
        b_q     <= '0;
      end else if (press[0]) begin
        case (state_q)
          LOAD_A: begin
            a_q     <= SW[3:0];
            state_q <= LOAD_B;
          end
          LOAD_B: begin
            b_q     <= SW[3:0];
            state_q <= LOAD_OP;
          end
          LOAD_OP: begin
            word_q  <= {SW[1:0], a_q, b_q};
            valid_q <= 1'b1;
            state_q <= READY;
          end
          default: state_q <= LOAD_A;
        endcase
      end
    end
  end

  assign operand_word = word_q;
  assign word_valid   = valid_q;
  assign seq_state    = state_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Random and directed stimulus for alu_operand_sequencer, checked every cycle against a
// behavioural model built from key-history windows and a step counter.

module tb_alu_operand_sequencer;
  localparam int DC = 4;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [9:0] SW       = '0;
  logic [1:0] KEY      = 2'b11;
  logic [9:0] operand_word;
  logic       word_valid;
  logic [1:0] seq_state;

  alu_operand_sequencer #(.DEBOUNCE_CYCLES(DC), .CNT_W(3)) dut (
    .CLOCK_50    (CLOCK_50),
    .RESET_N     (RESET_N),
    .SW          (SW),
    .KEY         (KEY),
    .operand_word(operand_word),
    .word_valid  (word_valid),
    .seq_state   (seq_state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0, errors = 0;

  // model: kh[n] is the KEY value sampled n edges ago
  logic [1:0] kh[$];
  logic [1:0] lvl;
  int         st;
  logic [3:0] ah, bh;
  logic [9:0] word;
  logic       mv;
  int         vpulses, schg;
  logic [1:0] prev_ss;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    kh.delete();
    repeat (DC + 2) kh.push_back(2'b11);
    lvl = 2'b11; st = 0; ah = 0; bh = 0; word = 0; mv = 0;
  endtask

  // A key level flips once the synchronised value (2 samples late) has disagreed with it
  // for DC consecutive edges; a 1->0 flip is a press.
  task automatic model_edge();
    logic [1:0] ev;
    ev = 2'b00;
    kh.push_front(KEY);
    for (int k = 0; k < 2; k++) begin
      bit diff;
      diff = 1'b1;
      for (int j = 0; j < DC; j++) if (kh[2+j][k] == lvl[k]) diff = 1'b0;
      if (diff) begin
        ev[k]  = lvl[k];
        lvl[k] = ~lvl[k];
      end
    end
    void'(kh.pop_back());
    mv = 1'b0;
    if (ev[1]) begin
      st = 0; ah = 0; bh = 0;
    end else if (ev[0]) begin
      if (st == 0) ah = SW[3:0];
      else if (st == 1) bh = SW[3:0];
      else if (st == 2) begin
        word = {SW[1:0], ah, bh};
        mv   = 1'b1;
      end
      st = (st + 1) % 4;
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    chk("word", operand_word, word);
    chk("valid", word_valid, mv);
    chk("state", seq_state, st);
    if (word_valid) vpulses++;
    if (seq_state != prev_ss) schg++;
    prev_ss = seq_state;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic press(input int k, input logic [9:0] sw, input int hold);
    SW     = sw;
    KEY[k] = 1'b0;
    idle(hold);
    KEY[k] = 1'b1;
    idle(DC + 4);
  endtask

  task automatic do_reset();
    #2;
    KEY     = 2'b11;
    RESET_N = 1'b0;
    #1;
    chk("rst_word", operand_word, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_state", seq_state, 0);
    model_reset();
    prev_ss = 2'b00;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
  endtask

  initial begin
    int s0, v0, n;
    model_reset();
    vpulses = 0; schg = 0; prev_ss = 2'b00;
    #1;
    chk("rst_word", operand_word, 0);
    chk("rst_valid", word_valid, 0);
    chk("rst_state", seq_state, 0);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    RESET_N = 1'b1;
    idle(3);

    // basic sequence
    press(0, 10'h005, DC + 4); chk("basic_s1", seq_state, 1);
    press(0, 10'h003, DC + 4); chk("basic_s2", seq_state, 2);
    press(0, 10'h002, DC + 4);
    chk("basic_word", operand_word, 10'h253);
    chk("basic_s3", seq_state, 3);
    chk("basic_pulses", vpulses, 1);

    // bounce shorter than DC, then a clean hold
    schg = 0;
    for (int i = 0; i < 5; i++) begin
      KEY[0] = 1'b0; idle(2);
      KEY[0] = 1'b1; idle(2);
    end
    KEY[0] = 1'b0; idle(DC + 6);
    KEY[0] = 1'b1; idle(DC + 4);
    chk("bounce_events", schg, 1);
    chk("bounce_state", seq_state, 0);

    // cancel after A and B
    v0 = vpulses;
    press(0, 10'h00F, DC + 4);
    press(0, 10'h001, DC + 4);
    press(1, 10'h001, DC + 4);
    chk("cancel_state", seq_state, 0);
    chk("cancel_word", operand_word, 10'h253);
    chk("cancel_valid", vpulses, v0);
    press(0, 10'h000, DC + 4);
    press(0, 10'h000, DC + 4);
    press(0, 10'h001, DC + 4);
    chk("after_cancel_word", operand_word, 10'h100);

    // simultaneous press in LOAD_OP
    press(0, 10'h00A, DC + 4);
    press(0, 10'h00B, DC + 4);
    press(0, 10'h00C, DC + 4);
    chk("simul_pre", seq_state, 2);
    v0 = vpulses;
    KEY = 2'b00; idle(DC + 4);
    KEY = 2'b11; idle(DC + 4);
    chk("simul_state", seq_state, 0);
    chk("simul_word", operand_word, 10'h100);
    chk("simul_valid", vpulses, v0);

    // reset in LOAD_OP, then in the word_valid cycle
    press(0, 10'h007, DC + 4);
    press(0, 10'h009, DC + 4);
    do_reset();
    idle(DC + 4);
    press(0, 10'h007, DC + 4);
    press(0, 10'h009, DC + 4);
    SW = 10'h003; KEY[0] = 1'b0;
    n = 0;
    while (!mv && n < 4 * DC) begin tick(); n++; end
    chk("valid_seen", mv, 1);
    v0 = vpulses;
    do_reset();
    idle(DC + 6);
    chk("no_valid_after_rst", vpulses, v0);

    // held key with SW churn
    schg = 0;
    KEY[0] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      SW = 10'($urandom);
      tick();
    end
    chk("held_events", schg, 1);
    chk("held_state", seq_state, 1);
    KEY[0] = 1'b1; idle(DC + 4);
    chk("held_release", seq_state, 1);
    press(0, 10'($urandom), DC + 4);
    press(0, 10'($urandom), DC + 4);
    chk("held_state_ready", seq_state, 3);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      int k;
      k = ($urandom_range(0, 7) == 0) ? 1 : 0;
      if ($urandom_range(0, 3) == 0) begin
        KEY[k] = 1'b0; idle($urandom_range(1, DC - 1));
        KEY[k] = 1'b1; idle($urandom_range(1, 3));
      end
      if ($urandom_range(0, 29) == 0) do_reset();
      SW     = 10'($urandom);
      KEY[k] = 1'b0;
      n = $urandom_range(DC + 1, DC + 10);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 2) == 0) SW = 10'($urandom);
        tick();
      end
      KEY[k] = 1'b1;
      idle($urandom_range(DC + 2, DC + 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end stage for the switch-driven ALU. It debounces the two pushbuttons and steps through a capture sequence that loads operand A, operand B and a 2-bit opcode from the slide switches. It presents one registered 10-bit word, plus a one-cycle valid strobe, to the Arithmetic, Logical and Comparison stages that feed the result multiplexers. The downstream blocks see a stable operand word, not live switch values.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed before a debounced key level changes (10 ms at 50 MHz).
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- CLOCK_50  input  1  system clock; all state is on its rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- SW  input  10  slide switches; SW[3:0] is the capture field.
- KEY  input  2  pushbuttons, active-low. KEY[0] = capture/advance, KEY[1] = cancel.
- operand_word  output  10  {op[1:0], a[3:0], b[3:0]}, registered; drives the ALU stages.
- word_valid  output  1  one-cycle pulse when a new operand_word is published.
- seq_state  output  2  current state encoding; goes to status LEDs.

## Operation
- Input conditioning, applied to each KEY bit independently:
  - 2-flop synchroniser.
  - Debounce: the counter clears whenever the synchronised input equals the debounced level; otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - Press event: a one-cycle pulse when the debounced level goes 1→0. Releases generate no event.
- FSM states and seq_state encoding:
  - LOAD_A = 0
  - LOAD_B = 1
  - LOAD_OP = 2
  - READY = 3
- Transitions:
  - LOAD_A + press0: a_hold ← SW[3:0]; go to LOAD_B.
  - LOAD_B + press0: b_hold ← SW[3:0]; go to LOAD_OP.
  - LOAD_OP + press0: go to READY. In the same edge, operand_word ← {SW[1:0], a_hold, b_hold} and word_valid is asserted for the following cycle.
  - READY + press0: go to LOAD_A. operand_word is unchanged.
  - Any state + press1: go to LOAD_A. a_hold and b_hold clear to 0; operand_word is unchanged; no word_valid.
  - press0 and press1 in the same cycle: press1 wins, press0 is discarded.
- operand_word changes only on the LOAD_OP→READY transition or on reset. Downstream blocks hold the last valid word while a new one is being entered.
- SW changes between presses have no effect. Only the SW value at the press-event edge is captured.
- A held key produces exactly one event. Bounce shorter than DEBOUNCE_CYCLES produces no events.

## Timing
- Reset values, taking effect immediately on RESET_N low:
  - operand_word = 0
  - word_valid = 0
  - seq_state = LOAD_A
  - a_hold = b_hold = 0
  - synchroniser flops = 1 (released)
  - debounced levels = 1
  - counters = 0
- Reset deassertion is used as-is. Reset asserted mid-sequence discards partial captures and drops any pending word_valid.
- Latency from KEY falling (and held stable) to the press event: 2 synchroniser cycles + DEBOUNCE_CYCLES cycles, ±1 cycle.
- The state update and captures occur on the clock edge where the event is high. word_valid is high exactly the one cycle after the LOAD_OP capture edge, and operand_word is already valid in that cycle.
- word_valid never lasts more than one cycle. Back-to-back valids are separated by at least 4 press events.
- Counter wrap: none. Saturation is impossible because the counter clears at the threshold.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.

- Basic sequence: after reset, clean KEY[0] presses with SW=0x005, then 0x003, then 0x002. Required: operand_word=0x253 with a single word_valid pulse, and seq_state walks 0→1→2→3.
- Bounce rejection: KEY[0] toggles every 2 cycles for 20 cycles, then stays low. Required: exactly one press event, and seq_state advances by exactly 1.
- Cancel: capture A=0xF and B=0x1, then press KEY[1]. Required: seq_state=0, operand_word keeps its previous value (0x253), no word_valid. A following full sequence with SW[3:0] = 0x0, 0x0, 0x1 gives operand_word=0x100.
- Simultaneous press: KEY[0] and KEY[1] fall in the same cycle while in LOAD_OP. Required: seq_state=LOAD_A, no word_valid, operand_word unchanged.
- Reset mid-operation: assert RESET_N low while in LOAD_OP, and again in the cycle where word_valid would be high. Required: all outputs 0 and seq_state=0 asynchronously, with no word_valid after release.
- Held key and SW churn: hold KEY[0] low for 100 cycles while SW changes every cycle. Required: a single capture of the SW value at the event edge, and no further advance until release followed by a new press.
